// File: rtl/kicp_sram_arbiter.sv
// kicp_sram_arbiter
//   Serialises access to the single-port RAM256 macro among NREQ requesters
//   (0 = Wishbone ctrl, 1 = matrix multiply, 2 = matrix convolution).
//   Each access walks IDLE -> ACCESS -> RESP -> DONE, so done_o pulses three
//   cycles after the request is picked up and the peak rate is one access every
//   four cycles. Every output comes straight from a flop.
//   Optional feature: define KICP_SRAM_ARB_RR_EN for round-robin arbitration;
//   left undefined, the lowest requesting index always wins.

module kicp_sram_arbiter #(
  parameter int AWIDTH = 8,
  parameter int NREQ   = 3
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          we_i,
  input  logic [NREQ*4-1:0]        sel_i,
  input  logic [NREQ*AWIDTH-1:0]   addr_i,
  input  logic [NREQ*32-1:0]       wdata_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [NREQ-1:0]          done_o,
  output logic [31:0]              rdata_o,
  output logic                     busy_o,
  output logic                     sram_en_o,
  output logic [3:0]               sram_we_o,
  output logic [AWIDTH-1:0]        sram_addr_o,
  output logic [31:0]              sram_di_o,
  input  logic [31:0]              sram_do_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

`ifdef KICP_SRAM_ARB_RR_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     rr_next;
`endif

  logic [1:0]        state;
  logic              op_read;

  logic              win_valid;
  logic [NREQ-1:0]   win_onehot;
  logic              win_we;
  logic [3:0]        win_sel;
  logic [AWIDTH-1:0] win_addr;
  logic [31:0]       win_wdata;

  // Pick the winning requester and mux out its access fields.
  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path can
    // leave one unassigned and no latch is inferred.
    int idx;
    idx        = 0;
    win_valid  = 1'b0;
    win_onehot = '0;
    win_we     = 1'b0;
    win_sel    = '0;
    win_addr   = '0;
    win_wdata  = '0;
`ifdef KICP_SRAM_ARB_RR_EN
    rr_next    = rr_ptr;
`endif
    for (int i = 0; i < NREQ; i++) begin
`ifdef KICP_SRAM_ARB_RR_EN
      // Search starts at the pointer and wraps around.
      idx = (int'(rr_ptr) + i) % NREQ;
`else
      // Lowest index has fixed priority.
      idx = i;
`endif
      if (!win_valid && req_i[idx]) begin
        win_valid       = 1'b1;
        win_onehot[idx] = 1'b1;
        win_we          = we_i[idx];
        win_sel         = sel_i[idx*4 +: 4];
        win_addr        = addr_i[idx*AWIDTH +: AWIDTH];
        win_wdata       = wdata_i[idx*32 +: 32];
`ifdef KICP_SRAM_ARB_RR_EN
        rr_next         = PW'((idx + 1) % NREQ);
`endif
      end
    end
  end

  // Access sequencer: owns the SRAM pins and the handshake outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= ST_IDLE;
      op_read     <= 1'b0;
      gnt_o       <= '0;
      done_o      <= '0;
      rdata_o     <= '0;
      busy_o      <= 1'b0;
      sram_en_o   <= 1'b0;
      sram_we_o   <= '0;
      sram_addr_o <= '0;
      sram_di_o   <= '0;
`ifdef KICP_SRAM_ARB_RR_EN
      rr_ptr      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the values
      // present before the edge, independent of statement order.
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            gnt_o       <= win_onehot;
            busy_o      <= 1'b1;
            sram_en_o   <= 1'b1;
            sram_we_o   <= win_we ? win_sel : 4'b0000;
            sram_addr_o <= win_addr;
            sram_di_o   <= win_wdata;
            op_read     <= ~win_we;
            state       <= ST_ACCESS;
`ifdef KICP_SRAM_ARB_RR_EN
            rr_ptr      <= rr_next;
`endif
          end
        end
        ST_ACCESS: begin
          // The RAM captures EN/WE/A/Di at the end of this cycle.
          sram_en_o <= 1'b0;
          sram_we_o <= '0;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          // Do0 is valid now; a write leaves the last read data in place.
          if (op_read) begin
            rdata_o <= sram_do_i;
          end
          done_o <= gnt_o;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done_o <= '0;
          gnt_o  <= '0;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kicp_sram_arbiter.sv
// tb_kicp_sram_arbiter
//   Self-checking bench for kicp_sram_arbiter. A behavioural RAM256 sits on the
//   SRAM pins; expected data and grant order come from a word-level reference
//   memory and a pending-set arbitration model. Honours KICP_SRAM_ARB_RR_EN.

module tb_kicp_sram_arbiter;

  logic        wb_clk_i;
  logic        wb_rst_ni;
  logic [2:0]  req_i;
  logic [2:0]  we_i;
  logic [11:0] sel_i;
  logic [23:0] addr_i;
  logic [95:0] wdata_i;
  logic [2:0]  gnt_o;
  logic [2:0]  done_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic        sram_en_o;
  logic [3:0]  sram_we_o;
  logic [7:0]  sram_addr_o;
  logic [31:0] sram_di_o;
  logic [31:0] sram_do_i;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] ref_mem [256];
  int          m_ptr;
  int          got_idx[$];
  logic [31:0] got_rd[$];

  // Behavioural RAM256 storage
  logic [31:0] mem [256];

  kicp_sram_arbiter #(.AWIDTH(8), .NREQ(3)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .req_i       (req_i),
    .we_i        (we_i),
    .sel_i       (sel_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .busy_o      (busy_o),
    .sram_en_o   (sram_en_o),
    .sram_we_o   (sram_we_o),
    .sram_addr_o (sram_addr_o),
    .sram_di_o   (sram_di_o),
    .sram_do_i   (sram_do_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // RAM256 model: synchronous read-before-write, byte-enabled write.
  always @(posedge wb_clk_i) begin
    if (sram_en_o) begin
      sram_do_i <= mem[sram_addr_o];
      for (int b = 0; b < 4; b++)
        if (sram_we_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_di_o[8*b +: 8];
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Winner among a pending set under the configured policy.
  function automatic int pick(input logic [2:0] pend, input int ptr);
`ifdef KICP_SRAM_ARB_RR_EN
    for (int i = 0; i < 3; i++) if (pend[(ptr + i) % 3]) return (ptr + i) % 3;
`else
    for (int i = 0; i < 3; i++) if (pend[i]) return i;
`endif
    return -1;
  endfunction

  task automatic set_fields(input int k, input logic we, input logic [3:0] sel,
                            input logic [7:0] addr, input logic [31:0] data);
    we_i[k]            = we;
    sel_i[4*k +: 4]    = sel;
    addr_i[8*k +: 8]   = addr;
    wdata_i[32*k +: 32] = data;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 20 && busy_o; c++) begin
      @(posedge wb_clk_i); #1;
    end
  endtask

  task automatic apply_reset();
    wb_rst_ni = 1'b0;
    req_i = '0; we_i = '0; sel_i = '0; addr_i = '0; wdata_i = '0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_ni = 1'b1;
    m_ptr = 0;
  endtask

  // One access by requester k; returns latency in cycles (-1 on timeout).
  task automatic do_access(input int k, input logic we, input logic [3:0] sel,
                           input logic [7:0] addr, input logic [31:0] data,
                           output int lat, output logic [2:0] dn, output logic [31:0] rd,
                           output logic en1, output logic [3:0] we1);
    lat = -1; dn = '0; rd = '0; en1 = 1'b0; we1 = '0;
    wait_idle();
    set_fields(k, we, sel, addr, data);
    req_i[k] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge wb_clk_i); #1;
      if (c == 1) begin en1 = sram_en_o; we1 = sram_we_o; end
      if (done_o != 3'b000) begin
        lat = c; dn = done_o; rd = rdata_o;
        break;
      end
    end
    req_i[k] = 1'b0;
    m_ptr = (k + 1) % 3;
    if (we) ref_mem[addr] = merge(ref_mem[addr], data, sel);
  endtask

  // Raise the requests in mask together and log done owners in arrival order.
  task automatic drive_batch(input logic [2:0] mask, input bit keep0, input int n);
    int idx;
    got_idx.delete();
    got_rd.delete();
    wait_idle();
    req_i = mask;
    for (int c = 0; c < n * 4 + 12; c++) begin
      @(posedge wb_clk_i); #1;
      if (done_o != 3'b000) begin
        case (done_o)
          3'b001:  idx = 0;
          3'b010:  idx = 1;
          3'b100:  idx = 2;
          default: idx = 7;
        endcase
        got_idx.push_back(idx);
        got_rd.push_back(rdata_o);
        if (idx < 3 && !(keep0 && idx == 0)) req_i[idx] = 1'b0;
        if (got_idx.size() == n) break;
      end
    end
    req_i = '0;
    wait_idle();
  endtask

  task automatic test_reset();
    wb_rst_ni = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_i   = 3'($urandom);
      we_i    = 3'($urandom);
      sel_i   = 12'($urandom);
      addr_i  = 24'($urandom);
      wdata_i = {$urandom, $urandom, $urandom};
      @(posedge wb_clk_i); #1;
      total++;
      if ({gnt_o, done_o, rdata_o, busy_o, sram_en_o, sram_we_o, sram_addr_o, sram_di_o} !== 84'd0) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: gnt=%b done=%b rdata=%h busy=%b en=%b we=%b addr=%h di=%h, want all 0",
                 c, gnt_o, done_o, rdata_o, busy_o, sram_en_o, sram_we_o, sram_addr_o, sram_di_o);
      end
    end
    apply_reset();
  endtask

  task automatic test_write_read();
    int lat; logic [2:0] dn; logic [31:0] rd; logic en1; logic [3:0] we1;
    do_access(0, 1'b1, 4'b1111, 8'h10, 32'hDEADBEEF, lat, dn, rd, en1, we1);
    total++;
    if (en1 !== 1'b1 || we1 !== 4'b1111) begin
      bad++; $display("FAIL write_pins: en=%b we=%b, want en=1 we=1111", en1, we1);
    end
    total++;
    if (lat != 3 || dn !== 3'b001) begin
      bad++; $display("FAIL write_done: latency=%0d done=%b, want 3 / 001", lat, dn);
    end
    @(posedge wb_clk_i); #1;
    total++;
    if (busy_o !== 1'b0 || gnt_o !== 3'b000 || done_o !== 3'b000) begin
      bad++; $display("FAIL after_done: busy=%b gnt=%b done=%b, want 0/000/000", busy_o, gnt_o, done_o);
    end
    do_access(0, 1'b0, 4'b0000, 8'h10, 32'h0, lat, dn, rd, en1, we1);
    total++;
    if (en1 !== 1'b1 || we1 !== 4'b0000) begin
      bad++; $display("FAIL read_pins: en=%b we=%b, want en=1 we=0000", en1, we1);
    end
    total++;
    if (lat != 3 || dn !== 3'b001 || rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL read_back: latency=%0d done=%b rdata=%h, want 3 / 001 / deadbeef", lat, dn, rd);
    end
  endtask

  task automatic test_byte_write();
    int lat; logic [2:0] dn; logic [31:0] rd; logic en1; logic [3:0] we1;
    do_access(1, 1'b1, 4'b0010, 8'h10, 32'h0000AA00, lat, dn, rd, en1, we1);
    total++;
    if (lat != 3 || dn !== 3'b010 || we1 !== 4'b0010) begin
      bad++; $display("FAIL byte_write: latency=%0d done=%b we=%b, want 3 / 010 / 0010", lat, dn, we1);
    end
    do_access(1, 1'b0, 4'b0000, 8'h10, 32'h0, lat, dn, rd, en1, we1);
    total++;
    if (dn !== 3'b010 || rd !== 32'hDEADAAEF) begin
      bad++; $display("FAIL byte_read: done=%b rdata=%h, want 010 / deadaaef", dn, rd);
    end
    // Zero byte-enable write: EN pulses, word is untouched, done still pulses.
    do_access(2, 1'b1, 4'b0000, 8'h10, 32'h12345678, lat, dn, rd, en1, we1);
    total++;
    if (lat != 3 || dn !== 3'b100 || en1 !== 1'b1 || we1 !== 4'b0000) begin
      bad++; $display("FAIL sel0_write: latency=%0d done=%b en=%b we=%b, want 3 / 100 / 1 / 0000",
                      lat, dn, en1, we1);
    end
    do_access(2, 1'b0, 4'b0000, 8'h10, 32'h0, lat, dn, rd, en1, we1);
    total++;
    if (rd !== 32'hDEADAAEF || rd !== ref_mem[8'h10]) begin
      bad++; $display("FAIL sel0_read: rdata=%h, want deadaaef", rd);
    end
  endtask

  task automatic test_simultaneous();
    int lat; logic [2:0] dn; logic [31:0] rd; logic en1; logic [3:0] we1;
    int exp_keep[4];
    do_access(1, 1'b1, 4'hF, 8'h11, 32'hA5A51111, lat, dn, rd, en1, we1);
    do_access(2, 1'b1, 4'hF, 8'h12, 32'h5A5A2222, lat, dn, rd, en1, we1);
    apply_reset();
    for (int k = 0; k < 3; k++) set_fields(k, 1'b0, 4'h0, 8'(8'h10 + k), 32'h0);
    drive_batch(3'b111, 1'b0, 3);
    total++;
    if (got_idx.size() != 3) begin
      bad++; $display("FAIL simul_count: got %0d dones, want 3", got_idx.size());
    end
    for (int j = 0; j < 3; j++) begin
      total++;
      if (got_idx[j] != j || got_rd[j] !== ref_mem[8'(8'h10 + j)]) begin
        bad++; $display("FAIL simul_order[%0d]: owner=%0d rdata=%h, want %0d / %h",
                        j, got_idx[j], got_rd[j], j, ref_mem[8'(8'h10 + j)]);
      end
    end
    // req0 keeps requesting; the others leave after one read.
    apply_reset();
`ifdef KICP_SRAM_ARB_RR_EN
    exp_keep = '{0, 1, 2, 0};
`else
    exp_keep = '{0, 0, 0, 0};
`endif
    drive_batch(3'b111, 1'b1, 4);
    for (int j = 0; j < 4; j++) begin
      total++;
      if (got_idx[j] != exp_keep[j]) begin
        bad++; $display("FAIL keep0_order[%0d]: owner=%0d, want %0d", j, got_idx[j], exp_keep[j]);
      end
    end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    int lat; logic [2:0] dn; logic [31:0] rd; logic en1; logic [3:0] we1;
    int dones;
    wait_idle();
    set_fields(0, 1'b1, 4'hF, 8'h30, $urandom);
    req_i[0] = 1'b1;
    @(posedge wb_clk_i); #1;
    total++;
    if (sram_en_o !== 1'b1 || busy_o !== 1'b1) begin
      bad++; $display("FAIL abort_access: en=%b busy=%b, want 1/1", sram_en_o, busy_o);
    end
    #2 wb_rst_ni = 1'b0;
    #1;
    total++;
    if ({gnt_o, done_o, rdata_o, busy_o, sram_en_o, sram_we_o, sram_addr_o, sram_di_o} !== 84'd0) begin
      bad++; $display("FAIL async_reset: gnt=%b done=%b busy=%b en=%b we=%b addr=%h, want all 0",
                      gnt_o, done_o, busy_o, sram_en_o, sram_we_o, sram_addr_o);
    end
    req_i = '0;
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge wb_clk_i); #1;
      if (done_o != 3'b000) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL abort_no_done: %0d done pulses, want 0", dones);
    end
    wb_rst_ni = 1'b1;
    m_ptr = 0;
    do_access(2, 1'b0, 4'h0, 8'h10, 32'h0, lat, dn, rd, en1, we1);
    total++;
    if (lat != 3 || dn !== 3'b100 || rd !== ref_mem[8'h10]) begin
      bad++; $display("FAIL post_reset_read: latency=%0d done=%b rdata=%h, want 3 / 100 / %h",
                      lat, dn, rd, ref_mem[8'h10]);
    end
  endtask

  task automatic test_drop_in_resp();
    int dones; int first; logic [31:0] rd;
    wait_idle();
    set_fields(0, 1'b0, 4'h0, 8'h11, 32'h0);
    req_i[0] = 1'b1;
    dones = 0; first = -1; rd = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge wb_clk_i); #1;
      if (c == 2) req_i[0] = 1'b0;
      if (done_o != 3'b000) begin
        dones++;
        if (first < 0) begin first = c; rd = rdata_o; end
        total++;
        if (done_o !== 3'b001) begin
          bad++; $display("FAIL drop_owner: done=%b, want 001", done_o);
        end
      end
    end
    m_ptr = 1;
    total++;
    if (dones != 1 || first != 3 || rd !== ref_mem[8'h11]) begin
      bad++; $display("FAIL drop_in_resp: pulses=%0d at cycle %0d rdata=%h, want 1 at 3 / %h",
                      dones, first, rd, ref_mem[8'h11]);
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL drop_idle: busy=%b, want 0", busy_o);
    end
  endtask

  task automatic test_random();
    int lat; logic [2:0] dn; logic [31:0] rd; logic en1; logic [3:0] we1;
    logic [2:0] mask, pend;
    logic       r_we[3];
    logic [3:0] r_sel[3];
    logic [7:0] r_addr[3];
    logic [31:0] r_data[3];
    int exp_idx[$];
    logic [31:0] exp_rd[$];
    int k;
    for (int a = 0; a < 8; a++)
      do_access(a % 3, 1'b1, 4'hF, 8'(8'h20 + a), $urandom, lat, dn, rd, en1, we1);
    for (int it = 0; it < 30; it++) begin
      mask = 3'($urandom_range(1, 7));
      for (int j = 0; j < 3; j++) begin
        r_we[j]   = 1'($urandom);
        r_sel[j]  = 4'($urandom);
        r_addr[j] = 8'(8'h20 + $urandom_range(0, 7));
        r_data[j] = $urandom;
        set_fields(j, r_we[j], r_sel[j], r_addr[j], r_data[j]);
      end
      exp_idx.delete();
      exp_rd.delete();
      pend = mask;
      while (pend != 3'b000) begin
        k = pick(pend, m_ptr);
        m_ptr = (k + 1) % 3;
        pend[k] = 1'b0;
        exp_idx.push_back(k);
        if (r_we[k]) begin
          ref_mem[r_addr[k]] = merge(ref_mem[r_addr[k]], r_data[k], r_sel[k]);
          exp_rd.push_back(32'h0);
        end else begin
          exp_rd.push_back(ref_mem[r_addr[k]]);
        end
      end
      drive_batch(mask, 1'b0, exp_idx.size());
      for (int j = 0; j < exp_idx.size(); j++) begin
        total++;
        if (got_idx[j] != exp_idx[j] || (!r_we[exp_idx[j]] && got_rd[j] !== exp_rd[j])) begin
          bad++; $display("FAIL random it%0d slot%0d: owner=%0d rdata=%h, want %0d / %h",
                          it, j, got_idx[j], got_rd[j], exp_idx[j], exp_rd[j]);
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ref_mem[a] = 32'h0;
    m_ptr = 0;
    wb_rst_ni = 1'b0;
    req_i = '0; we_i = '0; sel_i = '0; addr_i = '0; wdata_i = '0;
    #1;
    test_reset();
    test_write_read();
    test_byte_write();
    test_simultaneous();
    test_reset_mid();
    test_drop_in_resp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
